// File: rtl/filtro_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel debounce filter.
package filtro_pkg;

  localparam logic ESTABLE   = 1'b0;
  localparam logic VALIDANDO = 1'b1;

  function automatic int ms_to_ticks(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Bits needed to hold the value 'ticks' itself; never narrower than one bit.
  function automatic int cnt_width(input int ticks);
    return (ticks < 1) ? 1 : $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/filtro_rebote_canal.sv
// One debounce channel: input synchroniser, two-state validation FSM and long-press detector.
module filtro_rebote_canal
  import filtro_pkg::*;
#(
  parameter int DEB_TICKS   = 20,
  parameter int LONG_TICKS  = 50,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic pulso_real,
  output logic nivel,
  output logic flanco_sub,
  output logic flanco_baj,
  output logic long_pulse
);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   estado_q, estado_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   nivel_q, nivel_d;
  logic                   sub_q, sub_d;
  logic                   baj_q, baj_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulso_real};
    end
  end

  // The >= compare keeps a degenerate DEB_TICKS of 1 from counting forever.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    nivel_d  = nivel_q;
    sub_d    = 1'b0;
    baj_d    = 1'b0;
    case (estado_q)
      ESTABLE: begin
        cnt_d = '0;
        if (s != nivel_q) begin
          estado_d = VALIDANDO;
          cnt_d    = CW'(1);
        end
      end
      default: begin
        if (s == nivel_q) begin
          estado_d = ESTABLE;
          cnt_d    = '0;
        end else if (cnt_q >= DEB_LAST) begin
          estado_d = ESTABLE;
          cnt_d    = '0;
          nivel_d  = ~nivel_q;
          sub_d    = ~nivel_q;
          baj_d    = nivel_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= ESTABLE;
      cnt_q    <= '0;
      nivel_q  <= 1'b0;
      sub_q    <= 1'b0;
      baj_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      nivel_q  <= nivel_d;
      sub_q    <= sub_d;
      baj_q    <= baj_d;
    end
  end

  assign nivel      = nivel_q;
  assign flanco_sub = sub_q;
  assign flanco_baj = baj_q;

  generate
    if (LONG_TICKS > 0) begin : g_long
      localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);

      logic [CW-1:0] long_cnt_q, long_cnt_d;
      logic          armado_q, armado_d;
      logic          long_q, long_d;

      // A falling edge on this same cycle suppresses the pulse and re-arms.
      always_comb begin
        long_cnt_d = long_cnt_q;
        armado_d   = armado_q;
        long_d     = 1'b0;
        if (baj_d || !nivel_q) begin
          long_cnt_d = '0;
          armado_d   = 1'b1;
        end else if (armado_q) begin
          if (long_cnt_q >= LONG_LAST) begin
            long_d   = 1'b1;
            armado_d = 1'b0;
          end else begin
            long_cnt_d = long_cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          long_cnt_q <= '0;
          armado_q   <= 1'b0;
          long_q     <= 1'b0;
        end else begin
          long_cnt_q <= long_cnt_d;
          armado_q   <= armado_d;
          long_q     <= long_d;
        end
      end

      assign long_pulse = long_q;
    end else begin : g_no_long
      assign long_pulse = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/filtro_rebote_multi.sv
// Multi-channel debounce filter top: derives tick counts and replicates the channel N_CH times.
module filtro_rebote_multi
  import filtro_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 2,
  parameter int LONG_MS     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pulso_real,
  output logic [N_CH-1:0] nivel,
  output logic [N_CH-1:0] flanco_sub,
  output logic [N_CH-1:0] flanco_baj,
  output logic [N_CH-1:0] long_pulse
);

  localparam int DEB_TICKS  = ms_to_ticks(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_TICKS = ms_to_ticks(CLK_HZ, LONG_MS);
  localparam int MAX_TICKS  = (DEB_TICKS > LONG_TICKS) ? DEB_TICKS : LONG_TICKS;
  localparam int CW         = cnt_width(MAX_TICKS);

  for (genvar i = 0; i < N_CH; i++) begin : g_canal
    filtro_rebote_canal #(
      .DEB_TICKS  (DEB_TICKS),
      .LONG_TICKS (LONG_TICKS),
      .SYNC_STAGES(SYNC_STAGES),
      .CW         (CW)
    ) u_canal (
      .clk        (clk),
      .rst        (rst),
      .pulso_real (pulso_real[i]),
      .nivel      (nivel[i]),
      .flanco_sub (flanco_sub[i]),
      .flanco_baj (flanco_baj[i]),
      .long_pulse (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_filtro_rebote_multi.sv
// Directed bench for filtro_rebote_multi with 20-tick debounce and 50-tick long press.
module tb_filtro_rebote_multi;

  logic       clk;
  logic       rst;
  logic [3:0] pulsoReal;
  logic [3:0] nivel;
  logic [3:0] flancoSub;
  logic [3:0] flancoBaj;
  logic [3:0] longPulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] pulso;
    int         ciclos;
    logic [3:0] expNivel;
    logic [3:0] expSub;
    logic [3:0] expBaj;
    logic [3:0] expLong;
  } vec_t;

  vec_t tabla[15];

  filtro_rebote_multi #(
    .N_CH       (4),
    .CLK_HZ     (10_000),
    .DEBOUNCE_MS(2),
    .LONG_MS    (5),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pulso_real(pulsoReal),
    .nivel     (nivel),
    .flanco_sub(flancoSub),
    .flanco_baj(flancoBaj),
    .long_pulse(longPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [3:0] p, input int n);
    rst       = r;
    pulsoReal = p;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eN, input logic [3:0] eS,
                             input logic [3:0] eB, input logic [3:0] eL);
    checks++;
    if (nivel !== eN || flancoSub !== eS || flancoBaj !== eB || longPulse !== eL) begin
      errors++;
      $display("[TB] FAIL %s: nivel/sub/baj/long got %b/%b/%b/%b expected %b/%b/%b/%b",
               name, nivel, flancoSub, flancoBaj, longPulse, eN, eS, eB, eL);
    end
  endtask

  initial begin
    rst       = 1'b1;
    pulsoReal = 4'hF;

    tabla[0]  = '{"reset_c1",     1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0};
    tabla[1]  = '{"reset_c2",     1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0};
    tabla[2]  = '{"reset_c3",     1'b1, 4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0};
    tabla[3]  = '{"post_reset",   1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0};
    tabla[4]  = '{"ch0_pre_rise", 1'b0, 4'h1, 21, 4'h0, 4'h0, 4'h0, 4'h0};
    tabla[5]  = '{"ch0_rise",     1'b0, 4'h1, 1,  4'h1, 4'h1, 4'h0, 4'h0};
    tabla[6]  = '{"ch0_sub_once", 1'b0, 4'h1, 1,  4'h1, 4'h0, 4'h0, 4'h0};
    tabla[7]  = '{"ch0_pre_fall", 1'b0, 4'h0, 21, 4'h1, 4'h0, 4'h0, 4'h0};
    tabla[8]  = '{"ch0_fall",     1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h1, 4'h0};
    tabla[9]  = '{"ch0_idle",     1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0};
    tabla[10] = '{"sim_pre_rise", 1'b0, 4'hA, 21, 4'h0, 4'h0, 4'h0, 4'h0};
    tabla[11] = '{"sim_rise",     1'b0, 4'hA, 1,  4'hA, 4'hA, 4'h0, 4'h0};
    tabla[12] = '{"sim_sub_once", 1'b0, 4'hA, 1,  4'hA, 4'h0, 4'h0, 4'h0};
    tabla[13] = '{"sim_fall",     1'b0, 4'h0, 22, 4'h0, 4'h0, 4'hA, 4'h0};
    tabla[14] = '{"sim_idle",     1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tabla[i].rst, tabla[i].pulso, tabla[i].ciclos);
      checkOutput(tabla[i].name, tabla[i].expNivel, tabla[i].expSub,
                  tabla[i].expBaj, tabla[i].expLong);
    end

    // Bursts of 19 high cycles are one short of the debounce window.
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 19; k++) begin
        applyStimulus(1'b0, 4'h2, 1);
        checkOutput("ch1_bounce_high", 4'h0, 4'h0, 4'h0, 4'h0);
      end
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b0, 4'h0, 1);
        checkOutput("ch1_bounce_low", 4'h0, 4'h0, 4'h0, 4'h0);
      end
    end
    applyStimulus(1'b0, 4'h2, 21);
    checkOutput("ch1_hold_pre", 4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h2, 1);
    checkOutput("ch1_hold_rise", 4'h2, 4'h2, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h0, 22);
    checkOutput("ch1_release", 4'h0, 4'h0, 4'h2, 4'h0);
    applyStimulus(1'b0, 4'h0, 1);
    checkOutput("ch1_idle", 4'h0, 4'h0, 4'h0, 4'h0);

    // Long press on ch2: pulse 50 cycles after nivel rises, then never again while held.
    applyStimulus(1'b0, 4'h4, 22);
    checkOutput("ch2_rise", 4'h4, 4'h4, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h4, 49);
    checkOutput("ch2_long_pre", 4'h4, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h4, 1);
    checkOutput("ch2_long", 4'h4, 4'h0, 4'h0, 4'h4);
    for (int k = 0; k < 28; k++) begin
      applyStimulus(1'b0, 4'h4, 1);
      checkOutput("ch2_long_once", 4'h4, 4'h0, 4'h0, 4'h0);
    end
    applyStimulus(1'b0, 4'h0, 21);
    checkOutput("ch2_fall_pre", 4'h4, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h0, 1);
    checkOutput("ch2_fall", 4'h0, 4'h0, 4'h4, 4'h0);
    applyStimulus(1'b0, 4'h4, 22);
    checkOutput("ch2_rise2", 4'h4, 4'h4, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h4, 50);
    checkOutput("ch2_long2", 4'h4, 4'h0, 4'h0, 4'h4);

    // Release timed so the falling edge lands on the cycle the long count completes.
    applyStimulus(1'b0, 4'h0, 22);
    checkOutput("ch2_fall2", 4'h0, 4'h0, 4'h4, 4'h0);
    applyStimulus(1'b0, 4'h4, 22);
    checkOutput("ch2_rise3", 4'h4, 4'h4, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h4, 28);
    applyStimulus(1'b0, 4'h0, 21);
    checkOutput("ch2_collide_pre", 4'h4, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h0, 1);
    checkOutput("ch2_collide", 4'h0, 4'h0, 4'h4, 4'h0);
    applyStimulus(1'b0, 4'h0, 1);
    checkOutput("ch2_collide_after", 4'h0, 4'h0, 4'h0, 4'h0);

    // Reset with ch0 ten counts into validation restarts the full latency.
    applyStimulus(1'b0, 4'h1, 12);
    checkOutput("rst_mid_pre", 4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b1, 4'h1, 1);
    checkOutput("rst_mid", 4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h1, 21);
    checkOutput("rst_mid_hold", 4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h1, 1);
    checkOutput("rst_mid_rise", 4'h1, 4'h1, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filtro_rebote_multi.md
Name: filtro_rebote_multi

Overview:
Parametrised multi-channel debounce filter for push-buttons and switches on the board.
Per channel:
- synchronises the asynchronous raw input;
- requires the input to be stable for DEBOUNCE_MS before changing the filtered level;
- emits one-cycle rise and fall pulses;
- emits an optional one-shot long-press pulse.

It sits between the board pins and the control FSMs, replacing single-channel pulse stretching with true level debouncing.

Parameters:
N_CH, 4, number of independent channels
CLK_HZ, 50_000_000, clk frequency in Hz
DEBOUNCE_MS, 2, required stable time in ms (>=1)
LONG_MS, 1000, high time in ms before long_pulse fires (0 disables long_pulse, which is then tied to 0)
SYNC_STAGES, 2, synchroniser flip-flop depth (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pulso_real  in  N_CH  raw asynchronous inputs, active high
nivel  out  N_CH  debounced level
flanco_sub  out  N_CH  one-cycle pulse on debounced rising edge
flanco_baj  out  N_CH  one-cycle pulse on debounced falling edge
long_pulse  out  N_CH  one-cycle pulse when nivel has been high continuously for LONG_TICKS cycles

Behaviour:
- Derived constants:
  - DEB_TICKS = CLK_HZ/1000*DEBOUNCE_MS.
  - LONG_TICKS = CLK_HZ/1000*LONG_MS.
  - Counter width = clog2(max(DEB_TICKS, LONG_TICKS)+1).
  - All arithmetic is unsigned and integer-exact at elaboration; no runtime multiply.
- Reset (rst=1 at posedge clk) clears all of the following to 0 on that edge: synchroniser flops, counters, nivel, flanco_sub, flanco_baj, long_pulse, long-press armed flag.
- Synchroniser: pulso_real[i] passes through SYNC_STAGES flops; the last stage is s[i].
- Per-channel state machine has 2 states:
  - ESTABLE: s == nivel.
    - Debounce counter held at 0.
    - On a cycle with s != nivel, go to VALIDANDO with count = 1.
  - VALIDANDO:
    - If s == nivel, return to ESTABLE and set count = 0; a glitch shorter than DEB_TICKS is fully rejected.
    - Else if count == DEB_TICKS-1, then on this edge nivel toggles, state goes to ESTABLE, count goes to 0, and the matching flanco_sub or flanco_baj is 1 for exactly the next cycle.
    - Else count increments.
- Latency: a clean step on pulso_real appears on nivel SYNC_STAGES + DEB_TICKS cycles later. The edge pulse is coincident with the first cycle of the new nivel.
- Long press:
  - Uses a second counter per channel that runs while nivel=1.
  - When it reaches LONG_TICKS-1, long_pulse is 1 for one cycle and the channel is disarmed.
  - The counter saturates; it does not wrap.
  - The channel re-arms and the counter clears when nivel falls.
  - At most one long_pulse per press.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Simultaneous flanco_baj and a reached long count in the same cycle: flanco_baj wins and long_pulse stays 0.
- Reset mid-validation discards progress. If the input is held high through and after reset, nivel rises SYNC_STAGES + DEB_TICKS cycles after rst deasserts, with a normal flanco_sub.
- nivel is never X after the first clk edge with rst=1; no initial-value dependence is required.

Decomposition:
- Shared package filtro_pkg:
  - function ms_to_ticks(clk_hz, ms);
  - function cnt_width(ticks);
  - state encoding constants ESTABLE=1'b0 and VALIDANDO=1'b1.
- Sub-module filtro_rebote_canal:
  - one channel (synchroniser, debounce FSM, long-press counter);
  - instantiated N_CH times via generate;
  - the top is wiring only.

Test Plan:
All tests use CLK_HZ=10_000, DEBOUNCE_MS=2 (DEB_TICKS=20), LONG_MS=5 (LONG_TICKS=50), SYNC_STAGES=2, N_CH=4.
- Reset: assert rst 3 cycles with pulso_real=4'hF -> all outputs 0 during reset and on the first cycle after.
- Clean press ch0: pulso_real[0] 0->1 and held -> nivel[0]=1 exactly 22 cycles later; flanco_sub[0]=1 for that single cycle; other channels stay 0.
- Bounce rejection ch1:
  - toggle pulso_real[1] with high bursts of 19 cycles separated by 3-cycle lows -> nivel[1] stays 0, with no pulses;
  - then hold high -> nivel[1] rises 22 cycles after the last rising edge.
- Release and long press ch2:
  - hold high 100 cycles -> flanco_sub, then long_pulse[2] once, 50 cycles after nivel rose;
  - release -> flanco_baj[2] 22 cycles later;
  - second press -> long_pulse fires again.
- Simultaneous: pulso_real=4'b1010 in the same cycle -> nivel[1] and nivel[3] rise together with both flanco_sub bits set for the same single cycle.
- Reset mid-operation: rst for 1 cycle at count=10 on ch0 while input held high -> nivel[0] rises 22 cycles after rst deasserts.
